io_2to1: RTL and testbench

Self-checking traffic harness for a 2-to-1 merge node (ns join/arbiter) under test. It drives two independent source channels, o0 and o1, each stamped with its own source address and carrying its own 4-bit sequence counter. It receives the merged stream on one sink channel, i0. The sink verifies source identity, destination, redundancy and per-source ordering, and reports results on the debug channel.

---
 rtl/io_2to1_if.sv | 27 ++
 rtl/io_2to1.sv | 198 +++++++++++++++++++
 tb/tb_io_2to1.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/io_2to1_if.sv
// One message channel: source/destination address, payload, redundancy, and a
// four-phase req/ack handshake. The message originator uses master.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface io_2to1_if #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) ();
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, dst, dat, red, req, input ack);
  modport slave  (input src, dst, dat, red, req, output ack);
endinterface

// File: rtl/io_2to1.sv
// Traffic harness for a 2-to-1 merge node: two counting sources and one
// checking sink with sticky error flags and first-sequence-error capture.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module calc_redun #(
  parameter int ASZ = 8,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] i_src,
  input  logic [ASZ-1:0] i_dst,
  input  logic [DSZ-1:0] i_dat,
  output logic [RSZ-1:0] o_red
);
  localparam int W = 2*ASZ + DSZ;
  logic [W-1:0] w_vec;
  assign w_vec = {i_src, i_dst, i_dat};

  // Bit j of the message folds into redundancy bit j mod RSZ.
  always_comb begin
    o_red = '0;
    for (int j = 0; j < W; j++) o_red[j % RSZ] = o_red[j % RSZ] ^ w_vec[j];
  end
endmodule

module io_2to1_src #(
  parameter int SRC_ADDR = 9,
  parameter int DST_ADDR = 1,
  parameter int ASZ = 8,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input logic        clk,
  input logic        reset,
  io_2to1_if.master  m
);
  typedef enum logic [1:0] {S_LOAD, S_RED, S_REQ, S_REL} st_t;
  localparam logic [ASZ-1:0] LP_SRC = ASZ'(SRC_ADDR);
  localparam logic [ASZ-1:0] LP_DST = ASZ'(DST_ADDR);

  st_t            r_st, w_nxt;
  logic [3:0]     r_cnt;
  logic [DSZ-1:0] r_dat;
  logic [RSZ-1:0] r_red, w_red;
  logic           r_req, w_req;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red (
    .i_src(LP_SRC), .i_dst(LP_DST), .i_dat(r_dat), .o_red(w_red));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st  <= S_LOAD;
      r_cnt <= '0;
      r_dat <= '0;
      r_red <= '0;
      r_req <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_req <= w_req;
      if (r_st == S_LOAD) begin
        r_dat <= DSZ'(r_cnt);
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_st == S_RED) r_red <= w_red;
    end
  end

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_LOAD: w_nxt = S_RED;
      S_RED:  w_nxt = S_REQ;
      S_REQ:  if (r_req && m.ack) w_nxt = S_REL;
      S_REL:  if (!m.ack) w_nxt = S_LOAD;
      default: w_nxt = S_LOAD;
    endcase
  end

  // req is registered so it rises one edge after entering REQ.
  always_comb w_req = (r_st == S_REQ) && !(r_req && m.ack);

  assign m.src = LP_SRC;
  assign m.dst = LP_DST;
  assign m.dat = r_dat;
  assign m.red = r_red;
  assign m.req = r_req;
endmodule

module io_2to1 #(
  parameter int SRC0_ADDR = 9,
  parameter int SRC1_ADDR = 10,
  parameter int DST_ADDR  = 1,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  io_2to1_if.master  o0,
  io_2to1_if.master  o1,
  io_2to1_if.slave   i0,
  output logic [3:0] dbg_leds,
  output logic [3:0] dbg_disp0,
  output logic [3:0] dbg_disp1
);
  typedef enum logic [1:0] {K_IDLE, K_CALC, K_CHK, K_ACK} kst_t;
  localparam logic [ASZ-1:0] LP_S0  = ASZ'(SRC0_ADDR);
  localparam logic [ASZ-1:0] LP_S1  = ASZ'(SRC1_ADDR);
  localparam logic [ASZ-1:0] LP_DST = ASZ'(DST_ADDR);

  io_2to1_src #(.SRC_ADDR(SRC0_ADDR), .DST_ADDR(DST_ADDR), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ))
    u_src0 (.clk(clk), .reset(reset), .m(o0));
  io_2to1_src #(.SRC_ADDR(SRC1_ADDR), .DST_ADDR(DST_ADDR), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ))
    u_src1 (.clk(clk), .reset(reset), .m(o1));

  kst_t           r_st, w_nxt;
  logic [ASZ-1:0] r_src, r_dst;
  logic [DSZ-1:0] r_dat;
  logic [RSZ-1:0] r_red, r_cred, w_cred;
  logic           r_ack, w_ack;
  logic [3:0]     r_leds, r_disp0, r_disp1, r_last0, r_last1;
  logic           r_seq_seen;
  logic           w_is0, w_is1, w_bad, w_err0, w_err1;
  logic [3:0]     w_rx, w_exp0, w_exp1;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red (
    .i_src(r_src), .i_dst(r_dst), .i_dat(r_dat), .o_red(w_cred));

  always_comb begin
    w_is0  = (r_src == LP_S0);
    w_is1  = (r_src == LP_S1);
    w_rx   = r_dat[3:0];
    w_exp0 = r_last0 + 4'd1;
    w_exp1 = r_last1 + 4'd1;
    w_bad  = !(w_is0 || w_is1) || (r_dst != LP_DST) || (r_red != r_cred) ||
             ((r_dat >> 4) != '0);
    w_err0 = w_is0 && (w_rx != w_exp0);
    w_err1 = w_is1 && (w_rx != w_exp1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= K_IDLE;
      r_src <= '0; r_dst <= '0; r_dat <= '0; r_red <= '0; r_cred <= '0;
      r_ack <= 1'b0;
      r_leds <= '0; r_disp0 <= '0; r_disp1 <= '0;
      r_last0 <= 4'hF; r_last1 <= 4'hF;
      r_seq_seen <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_ack <= w_ack;
      if (r_st == K_IDLE && w_nxt == K_CALC) begin
        r_src <= i0.src; r_dst <= i0.dst; r_dat <= i0.dat; r_red <= i0.red;
      end
      if (r_st == K_CALC) r_cred <= w_cred;
      if (r_st == K_CHK) begin
        r_leds[3] <= r_leds[3] | w_bad;
        r_leds[1] <= r_leds[1] | w_err0;
        r_leds[2] <= r_leds[2] | w_err1;
        if ((w_err0 || w_err1) && !r_seq_seen) begin
          r_seq_seen <= 1'b1;
          r_disp0    <= w_is0 ? w_exp0 : w_exp1;
          r_disp1    <= w_rx;
        end
        // Track what arrived, not what was expected, so a resync is visible.
        if (w_is0) r_last0 <= w_rx;
        if (w_is1) r_last1 <= w_rx;
      end
      r_leds[0] <= |r_leds[3:1];
    end
  end

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      K_IDLE: if (i0.req && !r_ack) w_nxt = K_CALC;
      K_CALC: w_nxt = K_CHK;
      K_CHK:  w_nxt = K_ACK;
      K_ACK:  if (r_ack && !i0.req) w_nxt = K_IDLE;
      default: w_nxt = K_IDLE;
    endcase
  end

  always_comb w_ack = (r_st == K_ACK) && !(r_ack && !i0.req);

  assign i0.ack    = r_ack;
  assign dbg_leds  = r_leds;
  assign dbg_disp0 = r_disp0;
  assign dbg_disp1 = r_disp1;
endmodule

// File: tb/tb_io_2to1.sv
// Bench for io_2to1: loopback and alternating-arbiter traffic, with injected
// data/source/redundancy faults and a reset pulse during the sink ack phase.
module tb_io_2to1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  io_2to1_if #(.ASZ(8), .DSZ(8), .RSZ(4)) o0_if ();
  io_2to1_if #(.ASZ(8), .DSZ(8), .RSZ(4)) o1_if ();
  io_2to1_if #(.ASZ(8), .DSZ(8), .RSZ(4)) i0_if ();
  logic [3:0] leds, disp0, disp1;

  io_2to1 #(.SRC0_ADDR(9), .SRC1_ADDR(10), .DST_ADDR(1), .ASZ(8), .DSZ(8), .RSZ(4)) dut (
    .clk(clk), .reset(reset), .o0(o0_if), .o1(o1_if), .i0(i0_if),
    .dbg_leds(leds), .dbg_disp0(disp0), .dbg_disp1(disp1));

  function automatic logic [3:0] tb_red(input logic [7:0] s, input logic [7:0] d, input logic [7:0] t);
    logic [23:0] v;
    logic [3:0]  r;
    v = {s, d, t};
    r = 4'd0;
    for (int k = 0; k < 6; k++) r = r ^ v[k*4 +: 4];
    return r;
  endfunction

  // mode 0: o0 looped to i0; mode 1: alternating arbiter between o0 and o1
  bit         mode;
  logic [1:0] cor_kind;   // 1: dat->7, 2: src->3, 3: flip red bit 0
  int         cor_idx;
  bit         chk_dat;
  int         o0_done;
  logic       o0_prev;
  logic       arb_busy, arb_sel, arb_pref;
  logic       gsel, gon, cor_on;
  logic [7:0] f_src, f_dst, f_dat;
  logic [3:0] f_red;

  assign gsel   = mode ? arb_sel : 1'b0;
  assign gon    = mode ? arb_busy : 1'b1;
  assign cor_on = (cor_kind != 2'd0) && !gsel && (o0_done == cor_idx);

  always_comb begin
    f_src = gsel ? o1_if.src : o0_if.src;
    f_dst = gsel ? o1_if.dst : o0_if.dst;
    f_dat = gsel ? o1_if.dat : o0_if.dat;
    f_red = gsel ? o1_if.red : o0_if.red;
    if (cor_on) begin
      case (cor_kind)
        2'd1: begin f_dat = 8'd7; f_red = tb_red(f_src, f_dst, f_dat); end
        2'd2: begin f_src = 8'd3; f_red = tb_red(f_src, f_dst, f_dat); end
        2'd3: f_red = f_red ^ 4'd1;
        default: ;
      endcase
    end
  end

  assign i0_if.src = f_src;
  assign i0_if.dst = f_dst;
  assign i0_if.dat = f_dat;
  assign i0_if.red = f_red;
  assign i0_if.req = gon & (gsel ? o1_if.req : o0_if.req);
  assign o0_if.ack = gon & !gsel & i0_if.ack;
  assign o1_if.ack = gon &  gsel & i0_if.ack;

  always @(posedge clk) begin
    if (reset) begin
      arb_busy <= 1'b0; arb_sel <= 1'b0; arb_pref <= 1'b0;
      o0_done <= 0; o0_prev <= 1'b0;
    end else begin
      o0_prev <= o0_if.req;
      if (o0_prev && !o0_if.req) o0_done <= o0_done + 1;
      if (!arb_busy) begin
        if (arb_pref ? o1_if.req : o0_if.req) begin
          arb_busy <= 1'b1; arb_sel <= arb_pref; arb_pref <= !arb_pref;
        end else if (arb_pref ? o0_if.req : o1_if.req) begin
          arb_busy <= 1'b1; arb_sel <= !arb_pref;
        end
      end else if (!(arb_sel ? o1_if.req : o0_if.req) && !i0_if.ack) begin
        arb_busy <= 1'b0;
      end
    end
  end

  // Sink-side scoreboard: each delivered message must carry its source's next count.
  int   nack, n0, n1, mon_bad;
  logic ack_prev;
  always @(negedge clk) begin
    if (reset) begin
      nack <= 0; n0 <= 0; n1 <= 0; mon_bad <= 0; ack_prev <= 1'b0;
    end else begin
      ack_prev <= i0_if.ack;
      if (i0_if.ack && !ack_prev) begin
        nack <= nack + 1;
        if (i0_if.src == 8'd9) begin
          n0 <= n0 + 1;
          if (chk_dat && (i0_if.dat != 8'(n0 % 16))) mon_bad <= mon_bad + 1;
        end else if (i0_if.src == 8'd10) begin
          n1 <= n1 + 1;
          if (chk_dat && (i0_if.dat != 8'(n1 % 16))) mon_bad <= mon_bad + 1;
        end else if (chk_dat) mon_bad <= mon_bad + 1;
        if (chk_dat && (i0_if.red != tb_red(i0_if.src, i0_if.dst, i0_if.dat) || i0_if.dst != 8'd1))
          mon_bad <= mon_bad + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  typedef struct {
    bit         md;
    int         nmsg;
    logic [1:0] kind;
    int         idx;
    logic [3:0] e_leds, e_d0, e_d1;
  } row_t;
  row_t tbl[7];

  task automatic run_row(input int r);
    int cyc;
    @(negedge clk);
    reset = 1'b1; mode = tbl[r].md; cor_kind = tbl[r].kind; cor_idx = tbl[r].idx;
    chk_dat = (tbl[r].kind == 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (nack < tbl[r].nmsg && cyc < 5000) begin @(posedge clk); cyc++; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check($sformatf("row%0d msgs", r), nack, tbl[r].nmsg);
    check($sformatf("row%0d leds", r), leds, tbl[r].e_leds);
    check($sformatf("row%0d disp0", r), disp0, tbl[r].e_d0);
    check($sformatf("row%0d disp1", r), disp1, tbl[r].e_d1);
    if (chk_dat) check($sformatf("row%0d scoreboard", r), mon_bad, 0);
    if (tbl[r].md) begin
      check($sformatf("row%0d src0 count", r), n0, 32);
      check($sformatf("row%0d src1 count", r), n1, 32);
    end else if (r == 0) begin
      check("row0 src0 count", n0, 40);
      check("row0 o1_req stuck", o1_if.req, 1);
      check("row0 o1_dat held", o1_if.dat, 0);
    end
  endtask

  logic [13:1] req_e, ack_e;

  initial begin
    tbl[0] = '{1'b0, 40, 2'd0, 0, 4'b0000, 4'd0, 4'd0};
    tbl[1] = '{1'b1, 64, 2'd0, 0, 4'b0000, 4'd0, 4'd0};
    tbl[2] = '{1'b0,  5, 2'd1, 4, 4'b0011, 4'd4, 4'd7};
    tbl[3] = '{1'b0,  6, 2'd1, 4, 4'b0011, 4'd4, 4'd7};
    tbl[4] = '{1'b0,  3, 2'd2, 2, 4'b1001, 4'd0, 4'd0};
    tbl[5] = '{1'b0,  4, 2'd2, 2, 4'b1011, 4'd2, 4'd3};
    tbl[6] = '{1'b0,  3, 2'd3, 2, 4'b1001, 4'd0, 4'd0};

    mode = 1'b0; cor_kind = 2'd0; cor_idx = 0; chk_dat = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst o0_req", o0_if.req, 0);
    check("rst o0_dat", o0_if.dat, 0);
    check("rst o0_red", o0_if.red, 0);
    check("rst o1_req", o1_if.req, 0);
    check("rst o0_src", o0_if.src, 9);
    check("rst o1_src", o1_if.src, 10);
    check("rst o0_dst", o0_if.dst, 1);
    check("rst i0_ack", i0_if.ack, 0);
    check("rst leds", leds, 0);
    check("rst disp0", disp0, 0);
    check("rst disp1", disp1, 0);
    reset = 1'b0;

    // Edge-by-edge handshake timing of the first loopback message.
    req_e = 13'b1000001111100;
    ack_e = 13'b0000011000000;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      check($sformatf("edge%0d o0_req", k), o0_if.req, req_e[k]);
      check($sformatf("edge%0d i0_ack", k), i0_if.ack, ack_e[k]);
      if (k == 2) check("edge2 o0_red", o0_if.red, tb_red(8'd9, 8'd1, 8'd0));
      if (k == 3) check("edge3 o1_req", o1_if.req, 1);
      if (k == 13) check("edge13 o0_dat", o0_if.dat, 1);
    end

    for (int r = 0; r < 7; r++) run_row(r);

    // Reset pulse while the sink is acknowledging (flags from last row still set).
    begin
      int cyc;
      cyc = 0;
      while (i0_if.ack !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
      check("pre-reset i0_ack", i0_if.ack, 1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("midack reset i0_ack", i0_if.ack, 0);
      check("midack reset o0_req", o0_if.req, 0);
      check("midack reset leds", leds, 0);
      @(negedge clk); reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        check($sformatf("post-reset edge%0d o0_req", k), o0_if.req, (k == 3) ? 1 : 0);
      end
      check("post-reset o0_dat", o0_if.dat, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
